// File: rtl/preamble_strip_mimo_if.sv
// Stream bundle between fine timing sync, the preamble stripper and the payload consumer.
// All N_CH antennas share one data word so they move in lockstep.
interface preamble_strip_mimo_if #(
  parameter int DATA_W   = 16,
  parameter int N_CH     = 2,
  parameter int OFFSET_W = 8,
  parameter int CNT_W    = 16
);
  logic                     in_valid;
  logic [N_CH*2*DATA_W-1:0] in_data;
  logic                     fine_done;
  logic [OFFSET_W-1:0]      fine_num;
  logic [CNT_W-1:0]         frame_len;
  logic                     abort;
  logic                     out_valid;
  logic [N_CH*2*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;
  logic                     overflow;

  modport master (
    output in_valid, in_data, fine_done, fine_num, frame_len, abort,
    input  out_valid, out_data, out_idx, out_last, busy, overflow
  );
  modport slave (
    input  in_valid, in_data, fine_done, fine_num, frame_len, abort,
    output out_valid, out_data, out_idx, out_last, busy, overflow
  );
endinterface

// File: rtl/preamble_strip_mimo.sv
// Multi-antenna preamble remover: buffers lockstep samples in one FIFO, drops
// fine_num+PRE_LEN head samples, then streams frame_len payload samples.
module preamble_strip_mimo #(
  parameter int DATA_W   = 16,
  parameter int N_CH     = 2,
  parameter int FIFO_AW  = 9,
  parameter int PRE_LEN  = 128,
  parameter int OFFSET_W = 8,
  parameter int CNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  preamble_strip_mimo_if.slave  bus
);
  localparam int W     = N_CH*2*DATA_W;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, CAPTURE, SKIP, STREAM, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         mem [DEPTH];
  logic [FIFO_AW:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     skip_q, flen_q, cnt_q;
  logic                 out_valid_q, out_last_q, overflow_q;
  logic [W-1:0]         out_data_q;
  logic [CNT_W-1:0]     out_idx_q;

  logic empty, full, acc_state, pop, pop_out, wr_en, ovf_set;
  logic skip_last, last_pop, latch;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM outputs: which side of the FIFO moves this cycle; abort freezes reads
  always_comb begin
    acc_state = 1'b0;
    pop       = 1'b0;
    pop_out   = 1'b0;
    case (state_q)
      IDLE, CAPTURE: acc_state = 1'b1;
      SKIP:          begin acc_state = 1'b1; pop = !empty; end
      STREAM:        begin acc_state = 1'b1; pop = !empty; pop_out = !empty; end
      default:       ;
    endcase
    if (bus.abort) begin
      acc_state = 1'b0;
      pop       = 1'b0;
      pop_out   = 1'b0;
    end
  end

  // a full FIFO still accepts a write when the same cycle frees a slot
  assign wr_en     = bus.in_valid && acc_state && (!full || pop);
  assign ovf_set   = bus.in_valid && acc_state && full && !pop;
  assign skip_last = (state_q == SKIP) && pop && (cnt_q == skip_q - ONE);
  assign last_pop  = pop_out && (flen_q != '0) && (cnt_q == flen_q - ONE);
  assign latch     = (state_q == CAPTURE) && bus.fine_done && !bus.abort;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = CAPTURE;
      CAPTURE: if (bus.fine_done) state_d = SKIP;
      SKIP:    if (skip_last) state_d = STREAM;
      STREAM:  if (last_pop) state_d = FLUSH;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= bus.in_data;
  end

  // cnt_q counts skipped words in SKIP and is the payload index in STREAM
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      skip_q   <= '0;
      flen_q   <= '0;
      cnt_q    <= '0;
    end else if (state_q == FLUSH) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (latch) begin
        skip_q <= CNT_W'(bus.fine_num) + CNT_W'(PRE_LEN);
        flen_q <= bus.frame_len;
        cnt_q  <= '0;
      end else if (pop) begin
        cnt_q <= skip_last ? '0 : cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= pop_out;
      out_data_q  <= pop_out ? mem[rd_ptr_q[FIFO_AW-1:0]] : '0;
      out_last_q  <= last_pop;
      overflow_q  <= overflow_q | ovf_set;
      if (pop_out)                out_idx_q <= cnt_q;
      else if (state_q == FLUSH)  out_idx_q <= '0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overflow  = overflow_q;
endmodule
